// File: rtl/smoldvi_tmds_decode_align.sv
// smoldvi_tmds_decode_align
// One DVI channel on the receive side. It takes 10-bit words from a free-running 1:10
// deserialiser and finds the symbol boundary by hunting for runs of control tokens in
// blanking. Once aligned, it TMDS-decodes each symbol to 8-bit data, or to a control value.
//
//   state  | meaning
//   SEARCH | hunting for LOCK_COUNT back-to-back tokens at slip_offset
//   LOCKED | boundary found, decoding; drops back if data runs too long
module smoldvi_tmds_decode_align #(
  parameter int LOCK_COUNT     = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int MAX_DATA_RUN   = 1024
) (
  input  logic       clk_pix,
  input  logic       rst_n_pix,
  input  logic       en,
  input  logic [9:0] raw,
  output logic       den,
  output logic [7:0] d,
  output logic [1:0] c,
  output logic       locked,
  output logic [3:0] slip_offset
);

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  state_t      state_q, state_d;
  logic [9:0]  raw_prev_q;
  logic [9:0]  aligned_q;
  logic [3:0]  offset_q, offset_d;
  logic [15:0] tok_run_q, tok_run_d;
  logic [15:0] dat_run_q, dat_run_d;
  logic [15:0] idle_q, idle_d;
  logic        den_q, den_d;
  logic [7:0]  d_q, d_d;
  logic [1:0]  c_q, c_d;

  logic [19:0] pair;
  logic [9:0]  win;
  logic        is_tok;
  logic [1:0]  tok_val;
  logic [7:0]  t;
  logic [7:0]  dec;

  // Two consecutive deserialiser words side by side; earlier word sits in the low bits.
  assign pair = {raw, raw_prev_q};
  assign win  = 10'(pair >> offset_q);

  // Classify the stage-1 word as one of the four control tokens or data.
  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (aligned_q)
      TOK_C00: tok_val = 2'b00;
      TOK_C01: tok_val = 2'b01;
      TOK_C10: tok_val = 2'b10;
      TOK_C11: tok_val = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    t      = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
    dec    = 8'h00;
    dec[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aligned_q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

  // Alignment FSM and run/idle counters, driven by the stage-1 word.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    tok_run_d = tok_run_q;
    dat_run_d = dat_run_q;
    idle_d    = idle_q;
    if (!en) begin
      state_d   = ST_SEARCH;
      offset_d  = 4'd0;
      tok_run_d = 16'd0;
      dat_run_d = 16'd0;
      idle_d    = 16'd0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (is_tok) begin
            tok_run_d = tok_run_q + 16'd1;
            idle_d    = 16'd0;
          end else begin
            tok_run_d = 16'd0;
            idle_d    = idle_q + 16'd1;
          end
          if (tok_run_d == 16'(LOCK_COUNT)) begin
            state_d   = ST_LOCKED;
            dat_run_d = 16'd0;
            tok_run_d = 16'd0;
            idle_d    = 16'd0;
          end else if (idle_d == 16'(SEARCH_TIMEOUT)) begin
            offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            idle_d    = 16'd0;
            tok_run_d = 16'd0;
          end
        end
        ST_LOCKED: begin
          if (is_tok) begin
            dat_run_d = 16'd0;
          end else begin
            dat_run_d = dat_run_q + 16'd1;
            if (dat_run_d == 16'(MAX_DATA_RUN)) begin
              state_d   = ST_SEARCH;
              dat_run_d = 16'd0;
              tok_run_d = 16'd0;
              idle_d    = 16'd0;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // Stage-2 output values; everything is quiet unless enabled and locked.
  always_comb begin
    den_d = 1'b0;
    d_d   = 8'h00;
    c_d   = 2'b00;
    if (en && state_q == ST_LOCKED) begin
      if (is_tok) begin
        c_d = tok_val;
      end else begin
        den_d = 1'b1;
        d_d   = dec;
        c_d   = c_q;
      end
    end
  end

  // Pipeline, FSM and counter registers.
  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      raw_prev_q <= 10'd0;
      aligned_q  <= 10'd0;
      state_q    <= ST_SEARCH;
      offset_q   <= 4'd0;
      tok_run_q  <= 16'd0;
      dat_run_q  <= 16'd0;
      idle_q     <= 16'd0;
      den_q      <= 1'b0;
      d_q        <= 8'h00;
      c_q        <= 2'b00;
    end else begin
      raw_prev_q <= raw;
      aligned_q  <= win;
      state_q    <= state_d;
      offset_q   <= offset_d;
      tok_run_q  <= tok_run_d;
      dat_run_q  <= dat_run_d;
      idle_q     <= idle_d;
      den_q      <= den_d;
      d_q        <= d_d;
      c_q        <= c_d;
    end
  end

  assign den         = den_q;
  assign d           = d_q;
  assign c           = c_q;
  assign locked      = (state_q == ST_LOCKED);
  assign slip_offset = offset_q;

endmodule

// File: tb/tb_smoldvi_tmds_decode_align.sv
// Directed bench for smoldvi_tmds_decode_align: a reference TMDS encoder feeds a
// rotated bit stream, and expected outputs go through a 2-deep scoreboard queue.
module tb_smoldvi_tmds_decode_align;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam int LOCK_LIMIT = 10 * (1024 + 800);

  logic       clk_pix = 1'b0;
  logic       rst_n_pix;
  logic       en;
  logic [9:0] raw;
  logic       den;
  logic [7:0] d;
  logic [1:0] c;
  logic       locked;
  logic [3:0] slip_offset;

  typedef struct {
    bit          chk;
    logic [10:0] exp;
  } sb_t;

  sb_t        sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rot = 0;
  logic [9:0] prev_sym = 10'd0;
  int         enc_cnt = 0;
  logic [1:0] c_exp = 2'b00;

  smoldvi_tmds_decode_align dut (
    .clk_pix     (clk_pix),
    .rst_n_pix   (rst_n_pix),
    .en          (en),
    .raw         (raw),
    .den         (den),
    .d           (d),
    .c           (c),
    .locked      (locked),
    .slip_offset (slip_offset)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard DVI transmit encoder with running disparity.
  function automatic logic [9:0] tmds_enc(input logic [7:0] b);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, n1q, n0q;
    n1 = $countones(b);
    qm[0] = b[0];
    if (n1 > 4 || (n1 == 4 && b[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += (qm[8] ? 0 : -2) + n1q - n0q;
    end
    return q;
  endfunction

  // Drive one symbol through a deserialiser rotated by 'rot', push its expectation,
  // clock once, and compare the output belonging to the symbol sent two steps earlier.
  task automatic step(input logic [9:0] sym, input bit chk_en, input logic edn,
                      input logic [7:0] ed, input logic [1:0] ec);
    logic [19:0] cat;
    sb_t e;
    cat = {sym, prev_sym} >> (10 - rot);
    raw = cat[9:0];
    prev_sym = sym;
    e.chk = chk_en;
    e.exp = {edn, ed, ec};
    sbq.push_back(e);
    @(posedge clk_pix);
    #1;
    if (sbq.size() >= 3) begin
      e = sbq.pop_front();
      if (e.chk) chk("sb_out", {21'd0, den, d, c}, {21'd0, e.exp});
    end
  endtask

  task automatic tstep(input logic [9:0] tok, input logic [1:0] val);
    c_exp = val;
    step(tok, 1'b1, 1'b0, 8'h00, val);
  endtask

  task automatic dstep(input logic [7:0] b);
    step(tmds_enc(b), 1'b1, 1'b1, b, c_exp);
  endtask

  task automatic wait_lock(input string tag);
    int k;
    k = 0;
    while (locked !== 1'b1 && k < LOCK_LIMIT) begin
      step(T00, 1'b0, 1'b0, 8'h00, 2'b00);
      k++;
    end
    chk(tag, {31'd0, locked}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n_pix = 1'b0;
    #1;
    sbq.delete();
    c_exp = 2'b00;
    step(10'd0, 1'b0, 1'b0, 8'h00, 2'b00);
    step(10'd0, 1'b0, 1'b0, 8'h00, 2'b00);
    rst_n_pix = 1'b1;
  endtask

  initial begin
    rst_n_pix = 1'b0;
    en = 1'b1;
    raw = 10'd0;
    repeat (3) @(posedge clk_pix);
    #1;
    chk("rst_den", {31'd0, den}, 32'd0);
    chk("rst_d", {24'd0, d}, 32'd0);
    chk("rst_c", {30'd0, c}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_offset", {28'd0, slip_offset}, 32'd0);
    rst_n_pix = 1'b1;

    // All-zero input never matches a token: offset steps every 1024 cycles and wraps 9 -> 0.
    rot = 0;
    for (int i = 1; i <= 10240; i++) begin
      step(10'd0, 1'b0, 1'b0, 8'h00, 2'b00);
      if (i == 1023)  chk("to_before_first", {28'd0, slip_offset}, 32'd0);
      if (i == 1024)  chk("to_first_adv", {28'd0, slip_offset}, 32'd1);
      if (i == 9216)  chk("to_reach_9", {28'd0, slip_offset}, 32'd9);
      if (i == 10239) chk("to_hold_9", {28'd0, slip_offset}, 32'd9);
      if (i == 10240) chk("to_wrap_0", {28'd0, slip_offset}, 32'd0);
    end

    // 15 tokens then a data word, repeated: never locks, never times out.
    do_reset();
    for (int r = 0; r < 200; r++) begin
      for (int k = 0; k < 15; k++) step(T00, 1'b0, 1'b0, 8'h00, 2'b00);
      step(10'h1FF, 1'b0, 1'b0, 8'h00, 2'b00);
      chk("near_lock_unlocked", {31'd0, locked}, 32'd0);
    end
    chk("near_lock_offset", {28'd0, slip_offset}, 32'd0);

    // Rotation 3: search must settle on offset 3 and lock.
    do_reset();
    rot = 3;
    wait_lock("lock_rot3");
    chk("offset_rot3", {28'd0, slip_offset}, 32'd3);

    // Locked decode: tokens, hand-checked raw words, then encoded pixels.
    for (int k = 0; k < 3; k++) tstep(T00, 2'b00);
    step(10'h1FF, 1'b1, 1'b1, 8'h01, 2'b00);
    step(10'h100, 1'b1, 1'b1, 8'h00, 2'b00);
    for (int k = 0; k < 20; k++) dstep(8'($urandom_range(0, 255)));
    tstep(T10, 2'b10);
    for (int k = 0; k < 10; k++) dstep(8'($urandom_range(0, 255)));
    tstep(T11, 2'b11);
    for (int k = 0; k < 10; k++) dstep(8'($urandom_range(0, 255)));
    tstep(T01, 2'b01);
    for (int k = 0; k < 10; k++) dstep(8'($urandom_range(0, 255)));
    tstep(T00, 2'b00);

    // 1024 data words with no token: the last one still decodes, then lock drops.
    for (int k = 0; k < 1024; k++) dstep(8'($urandom_range(0, 255)));
    c_exp = 2'b00;
    for (int k = 0; k < 5; k++) step(tmds_enc(8'($urandom_range(0, 255))), 1'b1, 1'b0, 8'h00, 2'b00);
    chk("long_run_unlocked", {31'd0, locked}, 32'd0);
    chk("long_run_offset", {28'd0, slip_offset}, 32'd3);

    // Relock at the retained offset, then en=0 forces everything back next edge.
    wait_lock("relock_same_offset");
    en = 1'b0;
    step(T00, 1'b0, 1'b0, 8'h00, 2'b00);
    chk("en0_den", {31'd0, den}, 32'd0);
    chk("en0_locked", {31'd0, locked}, 32'd0);
    chk("en0_offset", {28'd0, slip_offset}, 32'd0);
    en = 1'b1;
    wait_lock("relock_after_en");
    chk("offset_after_en", {28'd0, slip_offset}, 32'd3);

    // Mid-line asynchronous reset, then recover.
    for (int k = 0; k < 3; k++) tstep(T00, 2'b00);
    for (int k = 0; k < 5; k++) dstep(8'($urandom_range(0, 255)));
    #2;
    rst_n_pix = 1'b0;
    #1;
    chk("arst_den", {31'd0, den}, 32'd0);
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_offset", {28'd0, slip_offset}, 32'd0);
    sbq.delete();
    c_exp = 2'b00;
    step(T00, 1'b0, 1'b0, 8'h00, 2'b00);
    step(T00, 1'b0, 1'b0, 8'h00, 2'b00);
    rst_n_pix = 1'b1;
    wait_lock("relock_after_rst");
    chk("offset_after_rst", {28'd0, slip_offset}, 32'd3);
    tstep(T11, 2'b11);
    for (int k = 0; k < 8; k++) dstep(8'($urandom_range(0, 255)));
    tstep(T00, 2'b00);
    step(T00, 1'b0, 1'b0, 8'h00, 2'b00);
    step(T00, 1'b0, 1'b0, 8'h00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
